// File: rtl/ddr3_cont_cpu_front.sv
// CPU-side front end of the DDR3 controller: command FIFO toward the scheduler
// and a four-slot tag-indexed reorder buffer that returns read data in order.
module ddr3_cont_cpu_front #(
  parameter int ADDR_W = 27,
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic              cpu_clk,
  input  logic              RESET_N,
  input  logic              init_done,
  input  logic              cpu_cmd_valid,
  output logic              cpu_cmd_ready,
  input  logic              cpu_cmd_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rdata_valid,
  output logic              sched_valid,
  input  logic              sched_ready,
  output logic              sched_write,
  output logic [ADDR_W-1:0] sched_addr,
  output logic [DATA_W-1:0] sched_wdata,
  output logic [1:0]        sched_tag,
  input  logic              mem_rdata_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [1:0]        mem_rtag,
  output logic              proto_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {S_WAIT_INIT, S_RUN} state_t;

  state_t            r_state;
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic [1:0]        r_tag_cnt;
  logic [1:0]        r_rel_ptr;
  logic [2:0]        r_outst;
  logic [3:0]        r_filled;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rdata_valid;
  logic              r_proto_err;

  logic              r_fifo_write [DEPTH];
  logic [ADDR_W-1:0] r_fifo_addr  [DEPTH];
  logic [DATA_W-1:0] r_fifo_wdata [DEPTH];
  logic [1:0]        r_fifo_tag   [DEPTH];
  logic [DATA_W-1:0] r_slot_data  [4];

  logic       w_ready;
  logic       w_push;
  logic       w_rd_push;
  logic       w_sched_valid;
  logic       w_pop;
  logic [1:0] w_rtag_off;
  logic       w_rtag_outst;
  logic       w_store;
  logic       w_bad;
  logic       w_release;
  logic [1:0] w_push_tag;
  logic [3:0] w_set;
  logic [3:0] w_clr;

  // Ready looks only at registered state, never at this cycle's pop or release.
  assign w_ready       = (r_state == S_RUN) && (r_count < CNT_W'(DEPTH)) && (r_outst < 3'd4);
  assign w_push        = cpu_cmd_valid & w_ready;
  assign w_rd_push     = w_push & ~cpu_cmd_write;
  assign w_push_tag    = cpu_cmd_write ? 2'd0 : r_tag_cnt;
  assign w_sched_valid = (r_count != '0);
  assign w_pop         = w_sched_valid & sched_ready;

  // Outstanding tags form the window [r_rel_ptr, r_rel_ptr + r_outst) mod 4.
  assign w_rtag_off   = mem_rtag - r_rel_ptr;
  assign w_rtag_outst = ({1'b0, w_rtag_off} < r_outst);
  assign w_store      = mem_rdata_valid & w_rtag_outst & ~r_filled[mem_rtag];
  assign w_bad        = mem_rdata_valid & ~w_store;
  assign w_release    = r_filled[r_rel_ptr];
  assign w_set        = w_store   ? (4'b0001 << mem_rtag)  : 4'b0000;
  assign w_clr        = w_release ? (4'b0001 << r_rel_ptr) : 4'b0000;

  always_ff @(posedge cpu_clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state       <= S_WAIT_INIT;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      r_tag_cnt     <= '0;
      r_rel_ptr     <= '0;
      r_outst       <= '0;
      r_filled      <= '0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
      r_proto_err   <= 1'b0;
    end else begin
      case (r_state)
        S_WAIT_INIT: if (init_done)  r_state <= S_RUN;
        S_RUN:       if (!init_done) r_state <= S_WAIT_INIT;
        default:     r_state <= S_WAIT_INIT;
      endcase

      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (w_rd_push) r_tag_cnt <= r_tag_cnt + 1'b1;
      r_outst  <= r_outst + {2'b00, w_rd_push} - {2'b00, w_release};
      r_filled <= (r_filled | w_set) & ~w_clr;

      r_rdata_valid <= w_release;
      if (w_release) begin
        r_rdata   <= r_slot_data[r_rel_ptr];
        r_rel_ptr <= r_rel_ptr + 1'b1;
      end

      if (w_bad) r_proto_err <= 1'b1;
    end
  end

  // Payload storage; validity is tracked by the reset control above.
  always_ff @(posedge cpu_clk) begin
    if (w_push) begin
      r_fifo_write[r_wptr] <= cpu_cmd_write;
      r_fifo_addr[r_wptr]  <= cpu_addr;
      r_fifo_wdata[r_wptr] <= cpu_wdata;
      r_fifo_tag[r_wptr]   <= w_push_tag;
    end
    if (w_store) r_slot_data[mem_rtag] <= mem_rdata;
  end

  assign cpu_cmd_ready   = w_ready;
  assign sched_valid     = w_sched_valid;
  assign sched_write     = r_fifo_write[r_rptr];
  assign sched_addr      = r_fifo_addr[r_rptr];
  assign sched_wdata     = r_fifo_wdata[r_rptr];
  assign sched_tag       = r_fifo_tag[r_rptr];
  assign cpu_rdata       = r_rdata;
  assign cpu_rdata_valid = r_rdata_valid;
  assign proto_err       = r_proto_err;

endmodule

// File: tb/tb_ddr3_cont_cpu_front.sv
// Directed bench for ddr3_cont_cpu_front: a queue-based reference model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_ddr3_cont_cpu_front;

  localparam int ADDR_W = 27;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 4;

  logic              cpu_clk;
  logic              RESET_N;
  logic              init_done;
  logic              cpu_cmd_valid;
  logic              cpu_cmd_ready;
  logic              cpu_cmd_write;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rdata_valid;
  logic              sched_valid;
  logic              sched_ready;
  logic              sched_write;
  logic [ADDR_W-1:0] sched_addr;
  logic [DATA_W-1:0] sched_wdata;
  logic [1:0]        sched_tag;
  logic              mem_rdata_valid;
  logic [DATA_W-1:0] mem_rdata;
  logic [1:0]        mem_rtag;
  logic              proto_err;

  ddr3_cont_cpu_front #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .cpu_clk(cpu_clk), .RESET_N(RESET_N), .init_done(init_done),
    .cpu_cmd_valid(cpu_cmd_valid), .cpu_cmd_ready(cpu_cmd_ready),
    .cpu_cmd_write(cpu_cmd_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_rdata_valid(cpu_rdata_valid),
    .sched_valid(sched_valid), .sched_ready(sched_ready), .sched_write(sched_write),
    .sched_addr(sched_addr), .sched_wdata(sched_wdata), .sched_tag(sched_tag),
    .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata), .mem_rtag(mem_rtag),
    .proto_err(proto_err)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: command queue, in-order list of outstanding reads.
  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [1:0]        tag;
  } cmd_t;

  typedef struct packed {
    logic [1:0]        tag;
    logic              have;
    logic [DATA_W-1:0] data;
  } rd_t;

  cmd_t        m_q[$];
  rd_t         m_pend[$];
  bit          m_run = 0;
  bit          m_err = 0;
  bit          m_vld = 0;
  logic [63:0] m_rdata = '0;
  logic [1:0]  m_tag = '0;

  function automatic bit model_ready();
    return m_run && (m_q.size() < DEPTH) && (m_pend.size() < 4);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pend.delete();
    m_run   = 0;
    m_err   = 0;
    m_vld   = 0;
    m_rdata = '0;
    m_tag   = '0;
  endtask

  task automatic model_step();
    bit   acc, pop, rel, found;
    cmd_t c;
    rd_t  r;
    acc = cpu_cmd_valid && model_ready();
    pop = (m_q.size() != 0) && sched_ready;
    rel = (m_pend.size() != 0) && m_pend[0].have;
    if (mem_rdata_valid) begin
      found = 0;
      foreach (m_pend[i]) begin
        if (m_pend[i].tag == mem_rtag) begin
          found = 1;
          if (m_pend[i].have) m_err = 1;
          else begin
            m_pend[i].have = 1'b1;
            m_pend[i].data = mem_rdata;
          end
        end
      end
      if (!found) m_err = 1;
    end
    if (rel) begin
      m_rdata = m_pend[0].data;
      m_vld   = 1;
      void'(m_pend.pop_front());
    end else begin
      m_vld = 0;
    end
    if (pop) void'(m_q.pop_front());
    if (acc) begin
      c.wr = cpu_cmd_write; c.addr = cpu_addr; c.wdata = cpu_wdata;
      c.tag = cpu_cmd_write ? 2'd0 : m_tag;
      m_q.push_back(c);
      if (!cpu_cmd_write) begin
        r.tag = m_tag; r.have = 1'b0; r.data = '0;
        m_pend.push_back(r);
        m_tag = m_tag + 2'd1;
      end
    end
    m_run = init_done;
  endtask

  task automatic model_compare();
    check("cmd_ready", 64'(cpu_cmd_ready), 64'(model_ready()));
    check("sched_valid", 64'(sched_valid), 64'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      check("sched_write", 64'(sched_write), 64'(m_q[0].wr));
      check("sched_addr", 64'(sched_addr), 64'(m_q[0].addr));
      check("sched_wdata", sched_wdata, m_q[0].wdata);
      check("sched_tag", 64'(sched_tag), 64'(m_q[0].tag));
    end
    check("rdata_valid", 64'(cpu_rdata_valid), 64'(m_vld));
    check("rdata", cpu_rdata, m_rdata);
    check("proto_err", 64'(proto_err), 64'(m_err));
  endtask

  always @(posedge cpu_clk or negedge RESET_N) begin
    if (!RESET_N) model_reset();
    else          model_step();
    #1 model_compare();
  end

  logic [63:0] got[$];
  always @(posedge cpu_clk) begin
    #1;
    if (cpu_rdata_valid === 1'b1) got.push_back(cpu_rdata);
  end

  initial begin
    cpu_clk = 0;
    forever #5 cpu_clk = ~cpu_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1);
  end

  // Caller is at a negedge; holds the request until accepted, returns one negedge later.
  task automatic send(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int k;
    cpu_cmd_valid = 1; cpu_cmd_write = wr; cpu_addr = a; cpu_wdata = d;
    k = 0;
    while (cpu_cmd_ready !== 1'b1 && k < 50) begin
      @(negedge cpu_clk);
      k++;
    end
    check("send_accept", 64'(cpu_cmd_ready), 64'd1);
    @(negedge cpu_clk);
    cpu_cmd_valid = 0;
  endtask

  task automatic mem_ret(input logic [1:0] t, input logic [63:0] d);
    mem_rdata_valid = 1; mem_rtag = t; mem_rdata = d;
    @(negedge cpu_clk);
  endtask

  initial begin
    RESET_N = 1; init_done = 0; cpu_cmd_valid = 0; cpu_cmd_write = 0;
    cpu_addr = '0; cpu_wdata = '0; sched_ready = 0;
    mem_rdata_valid = 0; mem_rdata = '0; mem_rtag = '0;

    // Power-up reset, then init handshake
    #2 RESET_N = 0;
    #1;
    check("rst_ready", 64'(cpu_cmd_ready), 64'd0);
    check("rst_sched_valid", 64'(sched_valid), 64'd0);
    repeat (5) @(negedge cpu_clk);
    RESET_N = 1;
    repeat (2) @(negedge cpu_clk);
    check("wait_init_ready", 64'(cpu_cmd_ready), 64'd0);
    init_done = 1;
    @(negedge cpu_clk);
    check("run_ready", 64'(cpu_cmd_ready), 64'd1);

    // Single write straight through
    sched_ready = 1;
    send(1'b1, 27'h100, 64'hA5A5);
    check("wr_sched_valid", 64'(sched_valid), 64'd1);
    check("wr_sched_write", 64'(sched_write), 64'd1);
    check("wr_sched_addr", 64'(sched_addr), 64'h100);
    check("wr_sched_wdata", sched_wdata, 64'hA5A5);
    check("wr_no_rdata", 64'(cpu_rdata_valid), 64'd0);
    @(negedge cpu_clk);
    check("wr_popped", 64'(sched_valid), 64'd0);

    // Fill FIFO with scheduler stalled, then drain in order
    sched_ready = 0;
    for (int i = 0; i < 4; i++) send(1'b1, ADDR_W'(32'h200 + 8 * i), 64'h1000 + 64'(i));
    cpu_cmd_valid = 1; cpu_cmd_write = 1; cpu_addr = 27'h220; cpu_wdata = 64'h1004;
    check("full_ready", 64'(cpu_cmd_ready), 64'd0);
    @(negedge cpu_clk);
    check("full_ready_hold", 64'(cpu_cmd_ready), 64'd0);
    cpu_cmd_valid = 0;
    sched_ready = 1;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", 64'(sched_valid), 64'd1);
      check("drain_addr", 64'(sched_addr), 64'h200 + 64'(8 * i));
      check("drain_wdata", sched_wdata, 64'h1000 + 64'(i));
      @(negedge cpu_clk);
    end
    check("drain_empty", 64'(sched_valid), 64'd0);

    // Four reads, out-of-order returns, fifth read stalls
    got.delete();
    for (int i = 0; i < 4; i++) send(1'b0, ADDR_W'(32'h1000 + 64 * i), '0);
    check("rd4_ready", 64'(cpu_cmd_ready), 64'd0);
    fork
      send(1'b0, 27'h2000, '0);
      begin
        mem_ret(2'd2, 64'hC0C0);
        mem_ret(2'd0, 64'hA0A0);
        mem_ret(2'd3, 64'hD0D0);
        mem_ret(2'd1, 64'hB0B0);
        mem_rdata_valid = 0;
      end
    join
    repeat (5) @(negedge cpu_clk);
    check("ord_count", 64'(got.size()), 64'd4);
    if (got.size() == 4) begin
      check("ord_A", got[0], 64'hA0A0);
      check("ord_B", got[1], 64'hB0B0);
      check("ord_C", got[2], 64'hC0C0);
      check("ord_D", got[3], 64'hD0D0);
    end

    // Return for the head tag: valid two cycles after the return
    mem_ret(2'd0, 64'hE0E0);
    mem_rdata_valid = 0;
    check("lat_m1", 64'(cpu_rdata_valid), 64'd0);
    @(negedge cpu_clk);
    check("lat_m2", 64'(cpu_rdata_valid), 64'd1);
    check("lat_data", cpu_rdata, 64'hE0E0);

    // Unsolicited return
    check("err_clear", 64'(proto_err), 64'd0);
    mem_ret(2'd1, 64'hBAD);
    mem_rdata_valid = 0;
    check("err_set", 64'(proto_err), 64'd1);
    check("err_no_rdata", 64'(cpu_rdata_valid), 64'd0);
    repeat (3) @(negedge cpu_clk);
    check("err_sticky", 64'(proto_err), 64'd1);

    // init_done drop: acceptance stops, queue still drains
    sched_ready = 0;
    send(1'b1, 27'h300, 64'h3);
    send(1'b1, 27'h308, 64'h4);
    init_done = 0;
    @(negedge cpu_clk);
    check("wi_ready", 64'(cpu_cmd_ready), 64'd0);
    check("wi_valid", 64'(sched_valid), 64'd1);
    sched_ready = 1;
    repeat (2) @(negedge cpu_clk);
    check("wi_drained", 64'(sched_valid), 64'd0);
    init_done = 1;
    @(negedge cpu_clk);
    check("wi_back", 64'(cpu_cmd_ready), 64'd1);

    // Reset with two reads queued and outstanding
    sched_ready = 0;
    send(1'b0, 27'h400, '0);
    send(1'b0, 27'h440, '0);
    RESET_N = 0;
    #1;
    check("mr_ready", 64'(cpu_cmd_ready), 64'd0);
    check("mr_sched_valid", 64'(sched_valid), 64'd0);
    check("mr_rvalid", 64'(cpu_rdata_valid), 64'd0);
    check("mr_rdata", cpu_rdata, 64'd0);
    check("mr_err", 64'(proto_err), 64'd0);
    repeat (3) @(negedge cpu_clk);
    RESET_N = 1;
    sched_ready = 1;
    @(negedge cpu_clk);
    mem_ret(2'd1, 64'h1111);
    mem_ret(2'd2, 64'h2222);
    mem_rdata_valid = 0;
    check("late_err", 64'(proto_err), 64'd1);
    repeat (3) @(negedge cpu_clk);
    check("late_no_rdata", 64'(cpu_rdata_valid), 64'd0);
    check("late_sched_empty", 64'(sched_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
